// File: rtl/playback_unit.sv
// playback_unit: word serializer for the channel data line.
// Accepts WIDTH-bit words over valid/ready into a single holding register,
// then shifts them out LSB-first, one bit per rising edge of samplePulse,
// so a recorder sampling the same pulse train reassembles the word.
module playback_unit #(
    parameter int   WIDTH    = 32,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    samplePulse,
    input  logic [WIDTH-1:0]        wordIn,
    input  logic                    wordValid,
    output logic                    wordReady,
    input  logic                    clearUnderrun,
    output logic                    dOut,
    output logic                    wordDone,
    output logic                    busy,
    output logic [$clog2(WIDTH):0]  bitCount,
    output logic                    underrun,
    output logic [3:0]              DBG
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_spQ;
    logic               r_armed;
    logic [WIDTH-1:0]   r_holdReg;
    logic               r_holdFull;
    logic [WIDTH-1:0]   r_shiftReg;
    logic [CNT_W-1:0]   r_bitCount;
    logic               r_dOut;
    logic               r_wordDone;
    logic               r_underrun;

    state_t             w_state;
    logic [WIDTH-1:0]   w_holdReg;
    logic               w_holdFull;
    logic [WIDTH-1:0]   w_shiftReg;
    logic [CNT_W-1:0]   w_bitCount;
    logic               w_dOut;
    logic               w_wordDone;
    logic               w_underrun;
    logic               w_setUnderrun;
    logic               w_strobe;
    logic               w_accept;

    // r_armed blocks a pulse that is already high when reset releases:
    // it only arms once samplePulse has been seen low.
    assign w_strobe  = enable & samplePulse & ~r_spQ & r_armed;
    assign wordReady = ~r_holdFull;
    assign w_accept  = wordValid & ~r_holdFull;

    assign dOut     = r_dOut;
    assign wordDone = r_wordDone;
    assign busy     = (r_state == ST_SHIFT);
    assign bitCount = r_bitCount;
    assign underrun = r_underrun;
    assign DBG      = {busy, r_holdFull, w_strobe, r_underrun};

    // Rising-edge detector on the sample pulse, with post-reset arming.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_spQ   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_spQ <= samplePulse;
            if (!samplePulse) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Next-state and datapath decisions for the hold/shift pair.
    always_comb begin
        w_state       = r_state;
        w_holdReg     = r_holdReg;
        w_holdFull    = r_holdFull;
        w_shiftReg    = r_shiftReg;
        w_bitCount    = r_bitCount;
        w_dOut        = r_dOut;
        w_wordDone    = 1'b0;
        w_setUnderrun = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_holdFull) begin
                    // Load the shifter; a coincident strobe emits bit 0 at once.
                    w_holdFull = 1'b0;
                    w_state    = ST_SHIFT;
                    if (w_strobe) begin
                        w_dOut     = r_holdReg[0];
                        w_shiftReg = r_holdReg >> 1;
                        w_bitCount = CNT_W'(1);
                    end else begin
                        w_shiftReg = r_holdReg;
                        w_bitCount = '0;
                    end
                end else if (w_strobe) begin
                    w_dOut        = IDLE_BIT;
                    w_setUnderrun = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_strobe) begin
                    w_dOut     = r_shiftReg[0];
                    w_shiftReg = r_shiftReg >> 1;
                    if (r_bitCount == LAST_CNT) begin
                        w_wordDone = 1'b1;
                        w_bitCount = '0;
                        if (r_holdFull) begin
                            // Chain straight into the held word: no gap.
                            w_shiftReg = r_holdReg;
                            w_holdFull = 1'b0;
                        end else begin
                            w_state = ST_IDLE;
                        end
                    end else begin
                        w_bitCount = r_bitCount + CNT_W'(1);
                    end
                end
            end
            default: w_state = ST_IDLE;
        endcase

        // Accept only when the hold register is empty, so it never
        // collides with a hold-to-shifter transfer in the same cycle.
        if (w_accept) begin
            w_holdReg  = wordIn;
            w_holdFull = 1'b1;
        end

        // Sticky flag: a set in the same cycle as a clear wins.
        w_underrun = r_underrun;
        if (clearUnderrun) begin
            w_underrun = 1'b0;
        end
        if (w_setUnderrun) begin
            w_underrun = 1'b1;
        end
    end

    // State, hold/shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_holdReg  <= '0;
            r_holdFull <= 1'b0;
            r_shiftReg <= '0;
            r_bitCount <= '0;
            r_dOut     <= IDLE_BIT;
            r_wordDone <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_holdReg  <= w_holdReg;
            r_holdFull <= w_holdFull;
            r_shiftReg <= w_shiftReg;
            r_bitCount <= w_bitCount;
            r_dOut     <= w_dOut;
            r_wordDone <= w_wordDone;
            r_underrun <= w_underrun;
        end
    end

endmodule

// File: tb/tb_playback_unit.sv
// tb_playback_unit: directed bench for playback_unit with hand-computed
// expected values and a small recorder model for the loopback case.
module tb_playback_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        samplePulse = 1'b0;
    logic [31:0] wordIn = '0;
    logic        wordValid = 1'b0;
    logic        wordReady;
    logic        clearUnderrun = 1'b0;
    logic        dOut;
    logic        wordDone;
    logic        busy;
    logic [5:0]  bitCount;
    logic        underrun;
    logic [3:0]  DBG;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    // Recorder model: captures the line when the pulse falls, by which
    // time the bit emitted on the rising edge is stable.
    logic        rec_spq  = 1'b0;
    logic [31:0] rec_word = '0;

    playback_unit #(.WIDTH(32), .IDLE_BIT(1'b0)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .samplePulse   (samplePulse),
        .wordIn        (wordIn),
        .wordValid     (wordValid),
        .wordReady     (wordReady),
        .clearUnderrun (clearUnderrun),
        .dOut          (dOut),
        .wordDone      (wordDone),
        .busy          (busy),
        .bitCount      (bitCount),
        .underrun      (underrun),
        .DBG           (DBG)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rec_spq <= samplePulse;
        if (rec_spq && !samplePulse) begin
            rec_word <= {dOut, rec_word[31:1]};
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (wordDone) done_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic write_word(input logic [31:0] w);
        wordIn    = w;
        wordValid = 1'b1;
        tick();
        wordValid = 1'b0;
    endtask

    // One rising edge on samplePulse followed by its mandatory low cycle.
    task automatic do_strobe(output logic b);
        samplePulse = 1'b1;
        tick();
        b = dOut;
        samplePulse = 1'b0;
        tick();
    endtask

    initial begin
        logic        b;
        logic [31:0] rx32;
        logic [63:0] rx64;

        // Reset state
        do_reset();
        check("rst_dOut",      64'(dOut),      64'd0);
        check("rst_wordDone",  64'(wordDone),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_bitCount",  64'(bitCount),  64'd0);
        check("rst_underrun",  64'(underrun),  64'd0);
        check("rst_wordReady", 64'(wordReady), 64'd1);
        check("rst_DBG",       64'(DBG),       64'd0);

        // Single word
        write_word(32'hA5A5_0F0F);
        check("acc_wordReady", 64'(wordReady), 64'd0);
        check("acc_DBG",       64'(DBG),       64'h4);
        tick();
        check("xfer_wordReady", 64'(wordReady), 64'd1);
        check("xfer_busy",      64'(busy),      64'd1);
        check("xfer_bitCount",  64'(bitCount),  64'd0);
        done_cnt = 0;
        rx32 = '0;
        for (int i = 0; i < 31; i++) begin
            do_strobe(b);
            rx32[i] = b;
        end
        check("single_done_early", 64'(done_cnt), 64'd0);
        do_strobe(b);
        rx32[31] = b;
        check("single_low_byte", 64'(rx32[7:0]), 64'h0F);
        check("single_word",     64'(rx32),      64'hA5A5_0F0F);
        check("single_done_cnt", 64'(done_cnt),  64'd1);
        check("single_busy_end", 64'(busy),      64'd0);
        check("single_cnt_end",  64'(bitCount),  64'd0);

        // Back-to-back
        do_reset();
        write_word(32'h0000_0001);
        tick();
        check("b2b_ready2", 64'(wordReady), 64'd1);
        write_word(32'h8000_0000);
        done_cnt = 0;
        rx64 = '0;
        for (int i = 0; i < 64; i++) begin
            do_strobe(b);
            rx64[i] = b;
        end
        check("b2b_bits",     rx64,             64'h8000_0000_0000_0001);
        check("b2b_done_cnt", 64'(done_cnt),    64'd2);
        check("b2b_underrun", 64'(underrun),    64'd0);
        check("b2b_busy_end", 64'(busy),        64'd0);

        // Underrun
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_strobe(b);
            check("udr_dOut", 64'(b), 64'd0);
        end
        check("udr_flag", 64'(underrun), 64'd1);
        clearUnderrun = 1'b1;
        samplePulse   = 1'b1;
        tick();
        clearUnderrun = 1'b0;
        check("udr_set_wins", 64'(underrun), 64'd1);
        samplePulse = 1'b0;
        tick();
        clearUnderrun = 1'b1;
        tick();
        clearUnderrun = 1'b0;
        check("udr_cleared", 64'(underrun), 64'd0);

        // Loopback through the recorder model
        do_reset();
        write_word(32'hDEAD_BEEF);
        tick();
        for (int i = 0; i < 32; i++) begin
            do_strobe(b);
        end
        tick();
        check("loopback_word", 64'(rec_word), 64'hDEAD_BEEF);

        // Enable and level pulse: 0xF3 -> bits 1,1,0,0,1,...
        do_reset();
        write_word(32'h0000_00F3);
        tick();
        samplePulse = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("lvl_cnt",  64'(bitCount), 64'd1);
        check("lvl_dOut", 64'(dOut),     64'd1);
        samplePulse = 1'b0;
        tick();
        do_strobe(b);
        check("lvl_bit1", 64'(b), 64'd1);
        do_strobe(b);
        check("lvl_bit2", 64'(b), 64'd0);
        check("lvl_cnt3", 64'(bitCount), 64'd3);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) do_strobe(b);
        check("en_cnt_frozen",  64'(bitCount), 64'd3);
        check("en_dOut_held",   64'(dOut),     64'd0);
        check("en_no_underrun", 64'(underrun), 64'd0);
        enable = 1'b1;
        tick();
        check("en_no_spurious", 64'(bitCount), 64'd3);
        do_strobe(b);
        check("en_bit3", 64'(b), 64'd0);
        do_strobe(b);
        check("en_bit4", 64'(b), 64'd1);
        check("en_cnt5", 64'(bitCount), 64'd5);

        // Reset mid-word with the hold register full
        do_reset();
        write_word(32'hFFFF_FFFF);
        tick();
        write_word(32'h1234_5678);
        for (int i = 0; i < 17; i++) do_strobe(b);
        check("mid_cnt17",  64'(bitCount),  64'd17);
        check("mid_full",   64'(wordReady), 64'd0);
        check("mid_dOut1",  64'(dOut),      64'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_cnt",   64'(bitCount),  64'd0);
        check("mid_rst_ready", 64'(wordReady), 64'd1);
        check("mid_rst_busy",  64'(busy),      64'd0);
        check("mid_rst_dOut",  64'(dOut),      64'd0);

        // Level pulse high across reset release gives no strobe until it drops
        samplePulse = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("rel_no_strobe", 64'(underrun), 64'd0);
        samplePulse = 1'b0;
        tick();
        do_strobe(b);
        check("rel_strobe_ok", 64'(underrun), 64'd1);
        check("rel_held_gone", 64'(busy),     64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
